gcd_job_arbiter: RTL and testbench

- Shares one subtractive GCD engine (datapath + controller pair) among NREQ requesters.
- Picks requesters round-robin and drives the engine's two-phase operand load on the shared data bus.
- Waits for engine done with a timeout, returns tagged result over a valid/ready response port, then flushes the engine for the next job.
- Sits between client logic and the GCD engine; the engine itself is unchanged.

---
 rtl/gcd_job_arbiter_if.sv | 37 +++
 rtl/gcd_job_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_gcd_job_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_job_arbiter_if.sv
// Bundle of requester, response and engine-side signals for gcd_job_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding clients and engine.
interface gcd_job_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;
  logic              eng_rst;
  logic              eng_start;
  logic [W-1:0]      eng_data;
  logic              eng_done;
  logic [W-1:0]      eng_result;

  modport slave (
    input  req, a_in, b_in, rsp_ready, eng_done, eng_result,
    output gnt, busy, rsp_valid, rsp_id, rsp_result, rsp_err,
           eng_rst, eng_start, eng_data
  );

  modport master (
    output req, a_in, b_in, rsp_ready, eng_done, eng_result,
    input  gnt, busy, rsp_valid, rsp_id, rsp_result, rsp_err,
           eng_rst, eng_start, eng_data
  );
endinterface

// File: rtl/gcd_job_arbiter.sv
// Round-robin front end that shares one subtractive GCD engine among NREQ
// requesters. It performs the two-phase operand load, waits for done with a
// timeout, and returns a tagged result. It then flushes the engine before
// the next job starts.
module gcd_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 2048
) (
  input  logic               clk,
  input  logic               rst,
  gcd_job_arbiter_if.slave   bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_RUN,
    S_RESP,
    S_FLUSH
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_err_q, rsp_err_d;
  logic           eng_start_q, eng_start_d;
  logic [W-1:0]   eng_data_q, eng_data_d;

  logic           win_found;
  logic [IDW-1:0] win;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  // Requester index k positions after p, wrapped into 0..NREQ-1.
  function automatic int wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return (s >= NREQ) ? (s - NREQ) : s;
  endfunction

  // Round-robin search: first pending request at or after the pointer.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && bus.req[wrap_idx(ptr_q, k)]) begin
        win_found = 1'b1;
        win       = IDW'(wrap_idx(ptr_q, k));
      end
    end
  end

  assign sel_a = bus.a_in[int'(win)*W +: W];
  assign sel_b = bus.b_in[int'(win)*W +: W];

  // Next-state and registered-output logic for the job sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    gnt_d        = '0;
    busy_d       = busy_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    eng_start_d  = 1'b0;
    eng_data_d   = eng_data_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d[win] = 1'b1;
          a_d        = sel_a;
          b_d        = sel_b;
          rsp_id_d   = win;
          ptr_d      = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          busy_d     = 1'b1;
          if (sel_a == '0 || sel_b == '0) begin
            // gcd(x,0) = x, so a zero operand never needs the engine.
            rsp_result_d = sel_a | sel_b;
            rsp_err_d    = 1'b0;
            state_d      = S_RESP;
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        eng_start_d = 1'b1;
        eng_data_d  = a_q;
        state_d     = S_LOAD_B;
      end
      S_LOAD_B: begin
        eng_data_d = b_q;
        cnt_d      = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        // Done is checked first, so it wins on the final timeout cycle.
        if (bus.eng_done) begin
          rsp_result_d = bus.eng_result;
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          eng_data_d  = '0;
          state_d     = S_FLUSH;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      S_FLUSH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      eng_start_q  <= eng_start_d;
      eng_data_q   <= eng_data_d;
    end
  end

  // Operand latches hold data only. They are always written before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_data   = eng_data_q;
  assign bus.eng_rst    = rst | (state_q == S_FLUSH);

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Scoreboard bench for gcd_job_arbiter. It contains a behavioural engine stub,
// round-robin and GCD reference models, and a monitor that checks every
// cycle.
module tb_gcd_job_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_job_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

  gcd_job_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  int tests = 0;
  int fails = 0;

  exp_t q[$];
  int   grant_log[$];
  logic [W-1:0] ja[NREQ];
  logic [W-1:0] jb[NREQ];
  logic hang = 1'b0;
  logic rand_arm = 1'b0;
  logic m_busy = 1'b0;
  logic m_flush = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x, y, t;
    x = a;
    y = b;
    if (x == 0 || y == 0) return W'(x | y);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // ---------------- engine stub ----------------
  initial begin
    int est, edly;
    logic [W-1:0] ea, eb;
    est = 0; edly = 0; ea = '0; eb = '0;
    bus.eng_done = 1'b0;
    bus.eng_result = '0;
    forever begin
      @(negedge clk);
      if (bus.eng_rst) begin
        est = 0;
        bus.eng_done = 1'b0;
        bus.eng_result = '0;
      end else begin
        case (est)
          0: if (bus.eng_start) begin ea = bus.eng_data; est = 1; end
          1: begin eb = bus.eng_data; est = 2; edly = $urandom_range(0, 6); end
          2: if (!hang) begin
               if (edly == 0) begin
                 bus.eng_done = 1'b1;
                 bus.eng_result = gcd_ref(ea, eb);
                 est = 3;
               end else edly--;
             end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int cyc, mptr, gcyc, d, w, starts, done_cyc;
    logic jz, jhang, seen_rise;
    logic [W-1:0] jA, jB;
    logic [31:0] exp_g;
    logic prev_valid, prev_err;
    logic [31:0] prev_id;
    logic [W-1:0] prev_res;
    exp_t e;
    cyc = 0; mptr = 0; gcyc = 0; starts = 0; done_cyc = -1;
    jz = 0; jhang = 0; seen_rise = 0; jA = '0; jB = '0;
    prev_valid = 0; prev_err = 0; prev_id = 0; prev_res = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_id", bus.rsp_id, 0);
        chk("rst_result", bus.rsp_result, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_start", bus.eng_start, 0);
        chk("rst_data", bus.eng_data, 0);
        chk("rst_eng_rst", bus.eng_rst, 1);
        q.delete();
        m_busy = 0; m_flush = 0; mptr = 0;
      end else if (m_flush) begin
        chk("idle_after_flush", bus.busy, 0);
        chk("single_flush", bus.eng_rst, 0);
        chk("no_gnt_after_flush", bus.gnt, 0);
        m_flush = 0; m_busy = 0;
      end else if (!m_busy) begin
        w = rr_pick(bus.req, mptr);
        exp_g = (w < 0) ? 32'd0 : (32'd1 << w);
        chk("gnt", bus.gnt, exp_g);
        chk("busy_vs_gnt", bus.busy, (w >= 0) ? 1 : 0);
        chk("idle_no_valid", bus.rsp_valid, 0);
        if (w >= 0) begin
          grant_log.push_back(w);
          mptr = (w + 1) % NREQ;
          m_busy = 1; gcyc = cyc; starts = 0; done_cyc = -1; seen_rise = 0;
          jA = ja[w]; jB = jb[w];
          jz = (jA == 0 || jB == 0);
          jhang = hang && !jz;
          e.id = w;
          e.err = jhang;
          e.res = jz ? (jA | jB) : (jhang ? '0 : gcd_ref(jA, jB));
          q.push_back(e);
        end
      end else begin
        d = cyc - gcyc;
        chk("gnt_while_busy", bus.gnt, 0);
        chk("busy", bus.busy, 1);
        if (bus.eng_start) starts++;
        if (!jz && d == 1) begin
          chk("load_a_start", bus.eng_start, 1);
          chk("load_a_data", bus.eng_data, jA);
        end
        if (!jz && d == 2) begin
          chk("load_b_start", bus.eng_start, 0);
          chk("load_b_data", bus.eng_data, jB);
        end
        if (bus.eng_done && done_cyc < 0) done_cyc = cyc;
        if (bus.rsp_valid && !prev_valid && !seen_rise) begin
          seen_rise = 1;
          if (jz) chk("zero_latency", d, 1);
          else if (jhang) chk("timeout_latency", d, TMO + 3);
          else chk("done_latency", cyc - done_cyc, 1);
        end
        if (prev_valid && bus.rsp_ready) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_rsp: got id %0d required no response", prev_id);
          end else begin
            e = q.pop_front();
            chk("rsp_id", prev_id, e.id);
            chk("rsp_result", prev_res, e.res);
            chk("rsp_err", prev_err, e.err);
          end
          chk("engine_starts", starts, jz ? 0 : 1);
          chk("valid_drop", bus.rsp_valid, 0);
          chk("flush_eng_rst", bus.eng_rst, 1);
          chk("flush_data", bus.eng_data, 0);
          m_flush = 1;
        end else if (prev_valid) begin
          chk("hold_valid", bus.rsp_valid, 1);
          chk("hold_id", bus.rsp_id, prev_id);
          chk("hold_result", bus.rsp_result, prev_res);
          chk("hold_err", bus.rsp_err, prev_err);
        end
      end
      prev_valid = bus.rsp_valid;
      prev_id    = bus.rsp_id;
      prev_res   = bus.rsp_result;
      prev_err   = bus.rsp_err;
    end
  end

  // ---------------- stimulus ----------------
  task automatic arm(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ja[i] = a;
    jb[i] = b;
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
    bus.req[i] = 1'b1;
  endtask

  task automatic arm_random(input int i);
    int g;
    logic [W-1:0] a, b;
    g = $urandom_range(1, 60);
    a = ($urandom_range(0, 9) == 0) ? '0 : W'(g * $urandom_range(1, 300));
    b = ($urandom_range(0, 9) == 0) ? '0 : W'(g * $urandom_range(1, 300));
    arm(i, a, b);
  endtask

  // One cycle: requesters drop req once granted; random mode re-arms and throttles ready.
  task automatic step();
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = bus.gnt;
    bus.req = bus.req & ~g;
    if (rand_arm) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && !g[i] && $urandom_range(0, 3) == 0) arm_random(i);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(bus.req == '0 && !m_busy && !m_flush && q.size() == 0)) begin
      step();
      n++;
      if (n > 8 * TMO + 400) begin
        tests++; fails++;
        $display("FAIL %s: got no completion required idle within cycle budget", tag);
        return;
      end
    end
    step();
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Four concurrent jobs, then requester 0 re-arms with 81/27.
    grant_log.delete();
    arm(0, 48, 18); arm(1, 35, 14); arm(2, 17, 5); arm(3, 100, 75);
    n = 0;
    do begin step(); n++; end while (!bus.gnt[0] && n < 20);
    arm(0, 81, 27);
    wait_idle("rr_burst");
    chk("rr_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("rr_order0", grant_log[0], 0);
      chk("rr_order1", grant_log[1], 1);
      chk("rr_order2", grant_log[2], 2);
      chk("rr_order3", grant_log[3], 3);
      chk("rr_order4", grant_log[4], 0);
    end

    // Zero operands bypass the engine.
    arm(2, 0, 12);
    wait_idle("zero_b");
    arm(2, 0, 0);
    wait_idle("zero_both");

    // Engine never finishes: timeout, then a normal job.
    hang = 1'b1;
    arm(1, 9, 6);
    wait_idle("timeout");
    hang = 1'b0;
    arm(1, 9, 6);
    wait_idle("after_timeout");

    // Back-pressure for five cycles in RESP.
    bus.rsp_ready = 1'b0;
    arm(3, 100, 75);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin step(); n++; end
    chk("bp_reached_resp", bus.rsp_valid, 1);
    repeat (5) begin
      step();
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 25);
    end
    bus.rsp_ready = 1'b1;
    wait_idle("backpressure");

    // Reset in the middle of RUN drops the job and clears the pointer.
    hang = 1'b1;
    arm(1, 10, 4);
    n = 0;
    while (!m_busy && n < 20) begin step(); n++; end
    repeat (4) step();
    rst = 1'b1;
    step();
    step();
    hang = 1'b0;
    rst = 1'b0;
    step();
    grant_log.delete();
    arm(0, 12, 8); arm(1, 21, 14); arm(2, 9, 3); arm(3, 64, 48);
    wait_idle("after_reset");
    if (grant_log.size() > 0) chk("first_after_reset", grant_log[0], 0);
    else chk("first_after_reset_count", grant_log.size(), 4);

    // Randomized traffic with random back-pressure.
    rand_arm = 1'b1;
    repeat (400) step();
    rand_arm = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle("random");

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
